// File: rtl/hgcal_input_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hgcal_input_packer : quantizes raw cell samples, packs N_FEAT of them into  |
// | one double-buffered, valid/ready vector for the layer-0 LUT fan-out.        |
// | rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module hgcal_input_packer #(
   parameter int N_FEAT   = 64,
   parameter int RAW_BITS = 10,
   parameter int IN_BITS  = 2,
   parameter int SHIFT    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [RAW_BITS-1:0]         in_data,
   input  logic                        in_valid,
   input  logic                        in_last,
   output logic                        in_ready,
   output logic [N_FEAT*IN_BITS-1:0]   out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        frame_err,
   output logic [15:0]                 frame_cnt
);

   localparam int                 c_idx_w = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(N_FEAT - 1);
   localparam int                 c_qmax  = (1 << IN_BITS) - 1;

   typedef enum logic [0:0] {
      s_fill = 1'b0,
      s_hold = 1'b1
   } state_t;

   state_t                      r_state;
   logic [c_idx_w-1:0]          r_idx;
   logic [N_FEAT*IN_BITS-1:0]   r_asm;
   logic [N_FEAT*IN_BITS-1:0]   r_out_data;
   logic                        r_out_valid;
   logic                        r_frame_err;
   logic [15:0]                 r_frame_cnt;

   logic [RAW_BITS-1:0]         w_shift;
   logic [IN_BITS-1:0]          w_q;
   logic [N_FEAT*IN_BITS-1:0]   w_vec;
   logic                        w_accept;
   logic                        w_deliver;
   logic                        w_at_last;
   logic                        w_done;
   logic                        w_err;

   assign in_ready  = (r_state == s_fill);
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign frame_err = r_frame_err;
   assign frame_cnt = r_frame_cnt;

   assign w_accept  = in_valid && in_ready;
   assign w_deliver = r_out_valid && out_ready;
   assign w_at_last = (r_idx == c_last);
   assign w_done    = w_accept && in_last && w_at_last;
   assign w_err     = w_accept && (in_last != w_at_last);

   // Saturating quantizer, then the assembly vector with the current beat merged in
   always_comb begin
      w_shift = in_data >> SHIFT;
      w_q     = (32'(w_shift) > c_qmax) ? IN_BITS'(c_qmax) : w_shift[IN_BITS-1:0];
      w_vec   = r_asm;
      w_vec[r_idx*IN_BITS +: IN_BITS] = w_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= s_fill;
         r_idx       <= '0;
         r_asm       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_frame_cnt <= r_frame_cnt + 16'(w_deliver);
         r_frame_err <= w_err;
         case (r_state)
            s_fill: begin
               if (w_accept) begin
                  r_asm <= w_vec;
                  r_idx <= (w_done || w_err) ? '0 : r_idx + c_idx_w'(1);
               end
               if (w_done && (!r_out_valid || out_ready)) begin
                  r_out_data  <= w_vec;
                  r_out_valid <= 1'b1;
               end else begin
                  // Output busy: park the completed frame in the assembly buffer
                  if (w_done)
                     r_state <= s_hold;
                  if (w_deliver)
                     r_out_valid <= 1'b0;
               end
            end
            s_hold: begin
               if (w_deliver) begin
                  r_out_data <= r_asm;
                  r_state    <= s_fill;
               end
            end
            default: r_state <= s_fill;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hgcal_input_packer.sv
`default_nettype none
// Self-checking bench for hgcal_input_packer with N_FEAT=4, RAW_BITS=10, IN_BITS=2, SHIFT=8.
module tb_hgcal_input_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        frame_err;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0][9:0] b;
      logic [7:0]      exp;
   } vec_t;
   vec_t tbl[6];

   hgcal_input_packer #(.N_FEAT(4), .RAW_BITS(10), .IN_BITS(2), .SHIFT(8)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [9:0] d, input logic last);
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0][9:0] b);
      for (int i = 0; i < 4; i++)
         send_beat(b[i], i == 3);
   endtask

   initial begin
      tbl[0].b = {10'h3FF, 10'h2FF, 10'h100, 10'h000}; tbl[0].exp = 8'hE4;
      tbl[1].b = {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}; tbl[1].exp = 8'hFF;
      tbl[2].b = {10'h300, 10'h100, 10'h0FF, 10'h0FF}; tbl[2].exp = 8'hD0;
      tbl[3].b = {10'h000, 10'h100, 10'h200, 10'h300}; tbl[3].exp = 8'h1B;
      tbl[4].b = {10'h3C0, 10'h0FF, 10'h200, 10'h1FF}; tbl[4].exp = 8'hC9;
      tbl[5].b = {10'h000, 10'h3FF, 10'h155, 10'h2AA}; tbl[5].exp = 8'h36;

      rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      step(); step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b1;
      step();

      // Quantization / packing table
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].b);
         check("tbl_valid", out_valid, 1);
         check("tbl_data", out_data, tbl[i].exp);
         step();
         check("tbl_valid_drop", out_valid, 0);
         check("tbl_cnt", frame_cnt, i + 1);
      end

      // Backpressure: A waits in output, B parks in HOLD
      out_ready = 1'b0;
      send_frame(tbl[0].b);
      check("bp_a_valid", out_valid, 1);
      for (int i = 0; i < 4; i++) begin
         send_beat(tbl[1].b[i], i == 3);
         check("bp_a_stable", out_data, 8'hE4);
      end
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
      step();
      check("bp_hold_ready2", in_ready, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_b_data", out_data, 8'hFF);
      check("bp_b_valid", out_valid, 1);
      check("bp_b_ready", in_ready, 1);
      check("bp_cnt", frame_cnt, 7);
      step();
      check("bp_b_stable", out_data, 8'hFF);
      out_ready = 1'b1;
      step();
      check("bp_b_drop", out_valid, 0);
      check("bp_cnt2", frame_cnt, 8);

      // Streaming: 10 back-to-back frames, one beat per cycle
      in_valid = 1'b1;
      for (int j = 0; j < 40; j++) begin
         in_data = 10'(((j / 4) % 4) * 256);
         in_last = (j % 4 == 3);
         step();
         check("st_in_ready", in_ready, 1);
         check("st_valid", out_valid, (j % 4 == 3) ? 1 : 0);
         if (j % 4 == 3)
            check("st_data", out_data, ((j / 4) % 4) * 8'h55);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      step();
      check("st_drop", out_valid, 0);
      check("st_cnt", frame_cnt, 18);

      // Framing error: early in_last
      send_beat(10'h3FF, 1'b0);
      send_beat(10'h3FF, 1'b0);
      send_beat(10'h3FF, 1'b1);
      check("fe1_err", frame_err, 1);
      check("fe1_valid", out_valid, 0);
      step();
      check("fe1_err_pulse", frame_err, 0);
      send_frame(tbl[3].b);
      check("fe1_next_valid", out_valid, 1);
      check("fe1_next_data", out_data, 8'h1B);
      step();
      // Framing error: missing in_last
      for (int i = 0; i < 4; i++)
         send_beat(10'h200, 1'b0);
      check("fe2_err", frame_err, 1);
      check("fe2_valid", out_valid, 0);
      send_frame(tbl[4].b);
      check("fe2_err_pulse", frame_err, 0);
      check("fe2_next_data", out_data, 8'hC9);
      step();
      check("fe_cnt", frame_cnt, 20);

      // Reset mid-frame
      send_beat(10'h3FF, 1'b0);
      send_beat(10'h3FF, 1'b0);
      rst = 1'b0;
      #1;
      check("rm_valid", out_valid, 0);
      check("rm_data", out_data, 0);
      check("rm_cnt", frame_cnt, 0);
      step();
      rst = 1'b1;
      step();
      send_frame(tbl[5].b);
      check("rm_next_data", out_data, 8'h36);
      check("rm_next_err", frame_err, 0);
      step();
      check("rm_next_cnt", frame_cnt, 1);

      // Reset while in HOLD
      out_ready = 1'b0;
      send_frame(tbl[2].b);
      send_frame(tbl[3].b);
      check("rh_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      check("rh_valid", out_valid, 0);
      check("rh_data", out_data, 0);
      check("rh_in_ready0", in_ready, 1);
      check("rh_err", frame_err, 0);
      step();
      rst = 1'b1;
      out_ready = 1'b1;
      step();
      send_frame(tbl[1].b);
      check("rh_next_data", out_data, 8'hFF);
      step();
      check("rh_next_cnt", frame_cnt, 1);

      // frame_cnt wrap
      force dut.r_frame_cnt = 16'hFFFF;
      step();
      release dut.r_frame_cnt;
      step();
      check("wrap_pre", frame_cnt, 16'hFFFF);
      send_frame(tbl[0].b);
      check("wrap_data", out_data, 8'hE4);
      step();
      check("wrap_cnt", frame_cnt, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hgcal_input_packer.md
Name: hgcal_input_packer

Overview:
- Upstream feeder for the first LUT layer of the HGCAL autoencoder. Accepts one raw sensor-cell value per beat on a valid/ready stream.
- Quantizes each value to IN_BITS by shift and unsigned saturation. Packs N_FEAT quantized features into one wide vector.
- Presents the vector to the layer-0 neuron fan-out as a registered, valid/ready-handshaked word.
- Double-buffered: the next frame assembles while the current vector waits for the consumer.

Parameters:
- N_FEAT, 64, features per frame (≥2).
- RAW_BITS, 10, width of the unsigned raw input sample.
- IN_BITS, 2, quantized feature width fed to the layer-0 LUTs.
- SHIFT, 8, right-shift applied before saturation (0 ≤ SHIFT < RAW_BITS).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_data  in  RAW_BITS  raw sample.
- in_valid  in  1  sample valid.
- in_last  in  1  marks final sample of a frame.
- in_ready  out  1  packer can accept a sample.
- out_data  out  N_FEAT*IN_BITS  packed vector; feature k at bits [k*IN_BITS +: IN_BITS].
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts vector.
- frame_err  out  1  one-cycle pulse on framing error.
- frame_cnt  out  16  count of vectors delivered (out_valid && out_ready), wraps at 2^16.

Behaviour:
- Reset (rst low, async): out_valid=0, out_data=0, frame_err=0, frame_cnt=0, feature index idx=0, assembly register=0, state=FILL. in_ready=1 once reset is released.
- Quantization: q = min(in_data >> SHIFT, 2^IN_BITS−1), unsigned. Example: RAW_BITS=10, SHIFT=8, IN_BITS=2 gives 0x0FF→0, 0x100→1, 0x3FF→3.
- A beat is accepted when in_valid && in_ready. The accepted q is written to assembly slot idx.
- States:
  - FILL: in_ready=1.
    - Accepted beat with idx<N_FEAT−1 and in_last=0: idx++.
    - Accepted beat with idx=N_FEAT−1 and in_last=1: frame complete.
      - If out slot free (out_valid=0, or out_ready=1 this cycle): load out_data with the full vector including this beat, out_valid=1 next cycle, idx=0, stay FILL.
      - Otherwise go to HOLD, idx=0.
    - Framing error: in_last=1 with idx<N_FEAT−1, or in_last=0 with idx=N_FEAT−1. Frame is discarded, frame_err pulses next cycle, idx=0, stay FILL, out register untouched.
  - HOLD: in_ready=0. When out_valid && out_ready, the assembly vector loads into out_data on the same edge, out_valid stays 1, and state returns to FILL.
- Latency: last accepted beat at edge t → out_valid=1 after edge t (visible cycle t+1).
- Output handshake:
  - out_data and out_valid stay stable while out_valid && !out_ready.
  - out_valid drops after handshake only if no new vector loads on the same edge.
- Simultaneous events:
  - Delivery and frame completion on the same edge: new vector loads and out_valid stays 1 (back-to-back, no bubble). frame_cnt increments once.
  - Sustained throughput: one sample per cycle with an always-ready consumer, with no stalls.
- Slots not yet written in a frame are never visible: out_data only updates from complete frames.
- frame_cnt increments on every out_valid && out_ready and wraps 0xFFFF→0.
- Asynchronous reset mid-frame or in HOLD returns everything to reset values immediately. A partial frame is lost and no frame_err is raised.

Test Plan:
- Quantization sweep (N_FEAT=4): frame in_data 0x000,0x100,0x2FF,0x3FF with in_last on beat 3, out_ready=1 → out_data=8'b11_10_01_00 one cycle after beat 3, out_valid for 1 cycle, frame_cnt=1.
- Backpressure/HOLD: out_ready=0, send two complete frames A and B.
  - Required: out_data=A held stable, in_ready=0 after B completes.
  - Raise out_ready for 1 cycle → out_data=B with no out_valid gap, in_ready=1 next cycle, frame_cnt=1.
- Streaming: 10 consecutive frames of N_FEAT beats with in_valid=1 and out_ready=1 → in_ready never drops, 10 vectors each spaced N_FEAT cycles, frame_cnt=10.
- Framing errors:
  - in_last on beat 2 of 4 → frame_err pulse, no out_valid; the next correct frame is delivered intact.
  - No in_last on beat 3 → frame_err pulse, frame discarded.
- Reset mid-operation: drop rst after 2 beats and again while in HOLD → outputs 0 immediately. The next full frame after release delivers correctly from idx 0.
- frame_cnt wrap: preload via 65536 handshakes (or force) → 0xFFFF→0x0000 on the next delivery.
